mem_stage: RTL
==============

# mem_stage

Memory-access stage of the five-stage ARM pipeline. It sits directly downstream of the EXE/MEM pipeline register and upstream of the MEM/WB register. It turns load/store requests into a request/acknowledge transaction on a word-addressed data-memory port, and asserts `freeze` to hold the upstream pipeline until the access completes. A watchdog counter bounds every transaction.

## Interface
Parameters:
- `ADDR_W`, 6: word-address width on the memory port (64 words).
- `BASE_ADDR`, 1024: byte address mapped to memory word 0.
- `TIMEOUT`, 15: maximum cycles spent in WAIT before the access is aborted (≥1).

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `wb_en_in`, `mem_r_en_in`, `mem_w_en_in` in 1 each: control bits from the EXE/MEM register.
- `alu_result_in` in 32: byte address for loads/stores; pass-through value otherwise.
- `dest_in` in 4: destination register.
- `val_rm_in` in 32: store data.
- `mem_req` out 1: memory request, held until `mem_ack`.
- `mem_we` out 1: 1 for write, 0 for read.
- `mem_addr` out ADDR_W: word address.
- `mem_wdata` out 32: write data.
- `mem_ack` in 1: memory completion strobe.
- `mem_rdata` in 32: read data, valid when `mem_ack` is 1.
- `freeze` out 1: stalls the PC register, IF/ID, ID/EX and EXE/MEM registers.
- `wb_en`, `mem_r_en` out 1 each: control bits to MEM/WB.
- `alu_result` out 32: to MEM/WB.
- `mem_data` out 32: load result.
- `dest` out 4: to MEM/WB.
- `mem_err` out 1: sticky timeout flag.

## Operation
- FSM has three states: IDLE, WAIT, DONE.
- IDLE:
  - If `mem_r_en_in` or `mem_w_en_in` is 1: latch `mem_we`, `mem_addr` and `mem_wdata`; set `mem_req`=1; clear the timeout counter; go to WAIT.
  - Otherwise stay in IDLE.
  - If both enables are 1, treat the operation as a write.
- Address mapping: `mem_addr = ((alu_result_in - BASE_ADDR) >> 2)[ADDR_W-1:0]`.
  - Byte offset bits [1:0] are ignored.
  - Out-of-range addresses wrap modulo 2^ADDR_W; no error is raised.
- WAIT:
  - On `mem_ack`=1: capture `mem_rdata` into `mem_data` (reads only; writes leave `mem_data` unchanged); drop `mem_req`; go to DONE.
  - If `mem_ack` is 0 and the counter equals TIMEOUT-1: drop `mem_req`; load `mem_data` with 32'hDEAD_BEEF; set `mem_err`=1; go to DONE.
  - Otherwise increment the counter.
- DONE: go to IDLE unconditionally. Inputs are never re-sampled in DONE, so the held instruction cannot retrigger an access.
- `freeze` is combinational: 1 when (state=IDLE and a mem enable is 1) or state=WAIT; 0 otherwise.
- Downstream outputs:
  - `wb_en = wb_en_in & ~freeze`.
  - `mem_r_en = mem_r_en_in & ~freeze`.
  - `alu_result` and `dest` pass through combinationally.
  - A frozen cycle therefore appears as a bubble to MEM/WB.
- `mem_err` clears only on reset.

## Timing
- Reset state:
  - State is IDLE; the counter is 0.
  - `mem_req`, `mem_we` = 0; `mem_addr` = 0; `mem_wdata` = 0; `mem_data` = 0; `mem_err` = 0.
  - `freeze` is forced to 0 while `rst`=0.
- Access with the enable seen in cycle N:
  - `mem_req` is high from cycle N+1.
  - If `mem_ack` arrives in cycle N+k (k≥1), state is DONE in N+k+1 and results are valid in N+k+1.
  - `freeze` is high for cycles N..N+k.
- Minimum load/store cost is 2 stall cycles (k=1).
- Timeout: with no ack, DONE is reached in cycle N+TIMEOUT+1.
- `mem_addr`, `mem_wdata` and `mem_we` are stable while `mem_req` is high.
- Ack handling:
  - `mem_ack` is ignored outside WAIT.
  - An ack in the same cycle as the timeout wins: the access completes normally and `mem_err` is not set.
- Reset asserted during WAIT: `mem_req` drops asynchronously and the access is abandoned. The memory side must tolerate abandoned requests.
- Non-memory instructions pass through with 0 cycles of added latency.

## Structure
- `mem_stage_pkg` holds:
  - the state enum (IDLE, WAIT, DONE);
  - default `BASE_ADDR`;
  - `TIMEOUT_DATA` = 32'hDEAD_BEEF.
- One sub-module, `mem_access_fsm`: contains the state register, timeout counter and request/ack logic. The top level holds the address/data latches and the pass-through logic.

## Test plan
- Load, ack after 1 cycle: `alu_result_in`=1028, `mem_rdata`=32'h1234_5678 → `mem_addr`=1, `mem_we`=0; `freeze` high 2 cycles; `mem_data`=32'h1234_5678 and `mem_r_en`=1 in DONE.
- Store, ack after 3 cycles: `alu_result_in`=1036, `val_rm_in`=32'hA5A5_0001 → `mem_addr`=3, `mem_we`=1, `mem_wdata`=32'hA5A5_0001; address and data stable for 3 cycles; `freeze` high 4 cycles; `wb_en`=0 throughout.
- Timeout with TIMEOUT=4 and no ack → `mem_req` high 4 cycles; `mem_data`=32'hDEAD_BEEF; `mem_err`=1 and it stays 1 until reset.
- ALU instruction (`wb_en_in`=1, `dest_in`=4'd7, no mem enables) → `freeze`=0; `wb_en`=1, `dest`=7 and `alu_result` pass through in the same cycle.
- Back-to-back loads at 1024 and 1032 → two separate transactions (`mem_addr` 0, then 2); no duplicate request issued from DONE.
- `rst` pulsed low during WAIT → `mem_req`, `freeze`, `mem_data` and `mem_err` are all 0 immediately; a later `mem_ack` is ignored.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: shared types and constants for the memory-access stage.
//   state_t           - access FSM states (IDLE, WAIT, DONE)
//   DEFAULT_BASE_ADDR - byte address mapped to data-memory word 0
//   TIMEOUT_DATA      - load result substituted when an access times out
package mem_stage_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int          DEFAULT_BASE_ADDR = 1024;
    localparam logic [31:0] TIMEOUT_DATA      = 32'hDEAD_BEEF;

endpackage

// File: rtl/mem_stage_access_fsm.sv
// mem_access_fsm: request/acknowledge sequencer with watchdog.
//   clk, rst      - clock, async active-low reset
//   access_en     - load or store present in the EXE/MEM register
//   mem_ack       - memory completion strobe
//   mem_req       - request to memory, high for the whole WAIT state
//   freeze        - upstream stall
//   start         - one-cycle strobe: latch address/data and issue request
//   ack_done      - one-cycle strobe: ack accepted in WAIT
//   timeout_done  - one-cycle strobe: watchdog expired without ack
//
// state | meaning
// IDLE  | no access in flight; a mem enable starts one
// WAIT  | request outstanding, watchdog running
// DONE  | access finished, results valid; enables not re-sampled
module mem_access_fsm
    import mem_stage_pkg::*;
#(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic access_en,
    input  logic mem_ack,
    output logic mem_req,
    output logic freeze,
    output logic start,
    output logic ack_done,
    output logic timeout_done
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Watchdog is a down-counter: loaded with TIMEOUT-1 on issue, terminal
    // count at zero, giving exactly TIMEOUT cycles in WAIT.
    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        start        = 1'b0;
        ack_done     = 1'b0;
        timeout_done = 1'b0;
        case (state)
            IDLE: begin
                if (access_en) begin
                    start     = 1'b1;
                    cnt_nxt   = CNT_W'(TIMEOUT - 1);
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                // ack takes priority over a coincident watchdog expiry
                if (mem_ack) begin
                    ack_done  = 1'b1;
                    state_nxt = DONE;
                end else if (cnt == '0) begin
                    timeout_done = 1'b1;
                    state_nxt    = DONE;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Decoded from the state register so it drops as soon as reset asserts.
    assign mem_req = (state == WAIT);
    assign freeze  = rst & (((state == IDLE) & access_en) | (state == WAIT));

endmodule

// File: rtl/mem_stage.sv
// mem_stage: memory-access pipeline stage between EXE/MEM and MEM/WB.
//   clk, rst                              - clock, async active-low reset
//   wb_en_in, mem_r_en_in, mem_w_en_in    - control from EXE/MEM
//   alu_result_in, dest_in, val_rm_in     - address/result, dest reg, store data
//   mem_req, mem_we, mem_addr, mem_wdata  - word-addressed memory request
//   mem_ack, mem_rdata                    - memory completion and read data
//   freeze                                - stall for PC, IF/ID, ID/EX, EXE/MEM
//   wb_en, mem_r_en, alu_result, dest     - to MEM/WB (bubbled while frozen)
//   mem_data                              - load result
//   mem_err                               - sticky watchdog-timeout flag
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int ADDR_W    = 6,
    parameter int BASE_ADDR = DEFAULT_BASE_ADDR,
    parameter int TIMEOUT   = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wb_en_in,
    input  logic              mem_r_en_in,
    input  logic              mem_w_en_in,
    input  logic [31:0]       alu_result_in,
    input  logic [3:0]        dest_in,
    input  logic [31:0]       val_rm_in,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ack,
    input  logic [31:0]       mem_rdata,
    output logic              freeze,
    output logic              wb_en,
    output logic              mem_r_en,
    output logic [31:0]       alu_result,
    output logic [31:0]       mem_data,
    output logic [3:0]        dest,
    output logic              mem_err
);

    logic start;
    logic ack_done;
    logic timeout_done;

    mem_access_fsm #(
        .TIMEOUT (TIMEOUT)
    ) u_fsm (
        .clk          (clk),
        .rst          (rst),
        .access_en    (mem_r_en_in | mem_w_en_in),
        .mem_ack      (mem_ack),
        .mem_req      (mem_req),
        .freeze       (freeze),
        .start        (start),
        .ack_done     (ack_done),
        .timeout_done (timeout_done)
    );

    // Request fields are captured once at issue and held for the whole
    // transaction. Both enables set counts as a store. Addresses outside the
    // mapped window simply wrap in the truncation.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else if (start) begin
            mem_we    <= mem_w_en_in;
            mem_addr  <= ADDR_W'((alu_result_in - 32'(BASE_ADDR)) >> 2);
            mem_wdata <= val_rm_in;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_data <= '0;
            mem_err  <= 1'b0;
        end else if (ack_done) begin
            if (!mem_we) begin
                mem_data <= mem_rdata;
            end
        end else if (timeout_done) begin
            mem_data <= TIMEOUT_DATA;
            mem_err  <= 1'b1;
        end
    end

    assign wb_en      = wb_en_in & ~freeze;
    assign mem_r_en   = mem_r_en_in & ~freeze;
    assign alu_result = alu_result_in;
    assign dest       = dest_in;

endmodule
